// File: rtl/pulse_handshake_tx_pkg.sv
// pulse_handshake_tx_pkg: shared state encodings and default sizing for the pulse handshake blocks
package pulse_handshake_tx_pkg;
    typedef enum logic [1:0] {
        PHS_IDLE = 2'd0,
        PHS_REQ  = 2'd1,
        PHS_ACKW = 2'd2
    } phs_state_t;
    localparam int DEF_CNT_W       = 4;
    localparam int DEF_SYNC_STAGES = 2;
endpackage

// File: rtl/pulse_handshake_tx_sync_bit.sv
// sync_bit: N-flop single-bit synchroniser, resets to 0
module sync_bit #(
    parameter int N = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic [N-1:0] ff;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) ff <= '0;
        else ff <= {ff[N-2:0], d};
    assign q = ff[N-1];
endmodule

// File: rtl/pulse_handshake_tx.sv
// pulse_handshake_tx: queues input pulses and sends each one across a 4-phase req/ack handshake
module pulse_handshake_tx
    import pulse_handshake_tx_pkg::*;
#(
    parameter int CNT_W       = DEF_CNT_W,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic             clka,
    input  logic             rst_n,
    input  logic             pulse_ina,
    input  logic             ack_in,
    input  logic             clr_ovf,
    output logic             req_out,
    output logic             busy,
    output logic [CNT_W-1:0] pending_cnt,
    output logic             overflow,
    output logic             done_pulse
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    phs_state_t state;
    logic ack_sync, queued, launch, fire, dec, drop, inc;
    sync_bit #(.N(SYNC_STAGES)) u_ack_sync (.clk(clka), .rst_n(rst_n), .d(ack_in), .q(ack_sync));
    assign queued = pending_cnt != '0;
    assign launch = queued || pulse_ina;
    assign fire   = launch && (state == PHS_IDLE || (state == PHS_ACKW && !ack_sync));
    assign dec    = fire && queued;
    assign drop   = pulse_ina && pending_cnt == CNT_MAX && !dec;
    // a pulse launched straight from an empty queue never touches the counter
    assign inc    = pulse_ina && !(fire && !queued) && !drop;
    assign busy   = state != PHS_IDLE || queued;
    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            state       <= PHS_IDLE;
            req_out     <= 1'b0;
            pending_cnt <= '0;
            overflow    <= 1'b0;
            done_pulse  <= 1'b0;
        end else begin
            pending_cnt <= pending_cnt + CNT_W'(inc) - CNT_W'(dec);
            overflow    <= drop || (overflow && !clr_ovf);
            done_pulse  <= state == PHS_ACKW && !ack_sync;
            case (state)
                PHS_IDLE: if (launch) begin
                    state   <= PHS_REQ;
                    req_out <= 1'b1;
                end
                PHS_REQ: if (ack_sync) begin
                    state   <= PHS_ACKW;
                    req_out <= 1'b0;
                end
                PHS_ACKW: if (!ack_sync) begin
                    state   <= launch ? PHS_REQ : PHS_IDLE;
                    req_out <= launch;
                end
                default: begin
                    state   <= PHS_IDLE;
                    req_out <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pulse_handshake_tx.sv
// tb_pulse_handshake_tx: directed scenarios for pulse_handshake_tx (CNT_W=4 and CNT_W=2 instances)
module tb_pulse_handshake_tx;
    logic clka = 1'b0, rst_n = 1'b0;
    logic pulse_ina = 1'b0, ack_in = 1'b0, clr_ovf = 1'b0;
    logic req_out, busy, overflow, done_pulse;
    logic [3:0] pending_cnt;
    logic pulse2 = 1'b0, ack2 = 1'b0, clr2 = 1'b0;
    logic req2, busy2, ovf2, done2;
    logic [1:0] pend2;
    int checks = 0, errors = 0;
    int req_rises = 0, dones = 0, dones_req = 0;
    logic prev_req = 1'b0;

    always #5 clka = ~clka;

    pulse_handshake_tx #(.CNT_W(4), .SYNC_STAGES(2)) dut (
        .clka(clka), .rst_n(rst_n), .pulse_ina(pulse_ina), .ack_in(ack_in), .clr_ovf(clr_ovf),
        .req_out(req_out), .busy(busy), .pending_cnt(pending_cnt), .overflow(overflow), .done_pulse(done_pulse));

    pulse_handshake_tx #(.CNT_W(2), .SYNC_STAGES(2)) dut2 (
        .clka(clka), .rst_n(rst_n), .pulse_ina(pulse2), .ack_in(ack2), .clr_ovf(clr2),
        .req_out(req2), .busy(busy2), .pending_cnt(pend2), .overflow(ovf2), .done_pulse(done2));

    always @(negedge clka) begin
        if (req_out && !prev_req) req_rises++;
        if (done_pulse) begin
            dones++;
            if (req_out) dones_req++;
        end
        prev_req = req_out;
    end

    task tick;
        @(posedge clka);
        #1;
    endtask

    task wait_req(input logic lvl);
        int n;
        n = 0;
        while (req_out !== lvl && n < 100) begin
            tick;
            n++;
        end
        checks++;
        if (req_out !== lvl) begin errors++; $display("FAIL wait_req: req_out=%b required %b within 100 cycles", req_out, lvl); end
    endtask

    task wait_idle;
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 200) begin
            tick;
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL wait_idle: busy=%b required 0 within 200 cycles", busy); end
    endtask

    // destination model: ack three cycles after req rises, drop ack once req falls
    task respond(input int count);
        for (int i = 0; i < count; i++) begin
            wait_req(1'b1);
            repeat (3) tick;
            ack_in = 1'b1;
            wait_req(1'b0);
            ack_in = 1'b0;
        end
    endtask

    task test_reset;
        checks++; if (req_out !== 1'b0) begin errors++; $display("FAIL reset_req: got %b required 0", req_out); end
        checks++; if (pending_cnt !== 4'd0) begin errors++; $display("FAIL reset_pending: got %0d required 0", pending_cnt); end
        checks++; if (overflow !== 1'b0 || done_pulse !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL reset_flags: ovf=%b done=%b busy=%b required 0 0 0", overflow, done_pulse, busy); end
        checks++; if (req2 !== 1'b0 || pend2 !== 2'd0 || ovf2 !== 1'b0 || done2 !== 1'b0) begin errors++; $display("FAIL reset_dut2: req=%b pend=%0d ovf=%b done=%b required all 0", req2, pend2, ovf2, done2); end
    endtask

    task test_single_pulse;
        int done_cnt;
        logic pend_bad;
        pend_bad = 1'b0;
        done_cnt = 0;
        tick;
        pulse_ina = 1'b1;
        tick;
        pulse_ina = 1'b0;
        checks++; if (req_out !== 1'b1) begin errors++; $display("FAIL single_req_rise: got %b required 1", req_out); end
        checks++; if (pending_cnt !== 4'd0) begin errors++; $display("FAIL single_pending_direct: got %0d required 0", pending_cnt); end
        repeat (3) tick;
        ack_in = 1'b1;
        tick;
        tick;
        checks++; if (req_out !== 1'b1) begin errors++; $display("FAIL single_req_hold: got %b required 1", req_out); end
        tick;
        checks++; if (req_out !== 1'b0) begin errors++; $display("FAIL single_req_fall: got %b required 0", req_out); end
        ack_in = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick;
            if (done_pulse === 1'b1) done_cnt++;
            if (pending_cnt !== 4'd0) pend_bad = 1'b1;
            if (i == 2) begin
                checks++; if (done_pulse !== 1'b1) begin errors++; $display("FAIL single_done_timing: got %b required 1", done_pulse); end
            end
        end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL single_done_count: got %0d required 1", done_cnt); end
        checks++; if (pend_bad !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL single_end: pend_bad=%b busy=%b required 0 0", pend_bad, busy); end
    endtask

    task test_burst;
        int r0, d0, q0;
        r0 = req_rises; d0 = dones; q0 = dones_req;
        fork
            begin
                pulse_ina = 1'b1;
                tick;
                checks++; if (pending_cnt !== 4'd0) begin errors++; $display("FAIL burst_pending_0: got %0d required 0", pending_cnt); end
                for (int k = 1; k <= 4; k++) begin
                    tick;
                    checks++; if (pending_cnt !== 4'(k)) begin errors++; $display("FAIL burst_pending_%0d: got %0d required %0d", k, pending_cnt, k); end
                end
                pulse_ina = 1'b0;
            end
            respond(5);
        join
        wait_idle;
        repeat (2) tick;
        checks++; if (req_rises - r0 != 5) begin errors++; $display("FAIL burst_req_rises: got %0d required 5", req_rises - r0); end
        checks++; if (dones - d0 != 5) begin errors++; $display("FAIL burst_dones: got %0d required 5", dones - d0); end
        checks++; if (dones_req - q0 != 4) begin errors++; $display("FAIL burst_back_to_back: got %0d required 4", dones_req - q0); end
    endtask

    task test_simultaneous;
        pulse_ina = 1'b1;
        repeat (3) tick;
        pulse_ina = 1'b0;
        checks++; if (pending_cnt !== 4'd2) begin errors++; $display("FAIL simul_setup: got %0d required 2", pending_cnt); end
        repeat (3) tick;
        ack_in = 1'b1;
        wait_req(1'b0);
        ack_in = 1'b0;
        tick;
        tick;
        pulse_ina = 1'b1;
        tick;
        pulse_ina = 1'b0;
        checks++; if (pending_cnt !== 4'd2) begin errors++; $display("FAIL simul_pending: got %0d required 2", pending_cnt); end
        checks++; if (req_out !== 1'b1 || done_pulse !== 1'b1) begin errors++; $display("FAIL simul_relaunch: req=%b done=%b required 1 1", req_out, done_pulse); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL simul_overflow: got %b required 0", overflow); end
        respond(3);
        wait_idle;
        checks++; if (pending_cnt !== 4'd0) begin errors++; $display("FAIL simul_drain: got %0d required 0", pending_cnt); end
    endtask

    task test_overflow;
        pulse2 = 1'b1;
        tick;
        checks++; if (pend2 !== 2'd0 || req2 !== 1'b1) begin errors++; $display("FAIL ovf_first: pend=%0d req=%b required 0 1", pend2, req2); end
        for (int k = 1; k <= 3; k++) begin
            tick;
            checks++; if (pend2 !== 2'(k)) begin errors++; $display("FAIL ovf_pending_%0d: got %0d required %0d", k, pend2, k); end
        end
        checks++; if (ovf2 !== 1'b0) begin errors++; $display("FAIL ovf_early: got %b required 0", ovf2); end
        tick;
        pulse2 = 1'b0;
        checks++; if (pend2 !== 2'd3 || ovf2 !== 1'b1) begin errors++; $display("FAIL ovf_drop: pend=%0d ovf=%b required 3 1", pend2, ovf2); end
        clr2 = 1'b1;
        tick;
        clr2 = 1'b0;
        checks++; if (pend2 !== 2'd3 || ovf2 !== 1'b0) begin errors++; $display("FAIL ovf_clear: pend=%0d ovf=%b required 3 0", pend2, ovf2); end
        pulse2 = 1'b1;
        clr2 = 1'b1;
        tick;
        pulse2 = 1'b0;
        clr2 = 1'b0;
        checks++; if (pend2 !== 2'd3 || ovf2 !== 1'b1) begin errors++; $display("FAIL ovf_set_wins: pend=%0d ovf=%b required 3 1", pend2, ovf2); end
    endtask

    task test_reset_mid;
        checks++; if (req2 !== 1'b1 || pend2 !== 2'd3) begin errors++; $display("FAIL rstmid_pre: req=%b pend=%0d required 1 3", req2, pend2); end
        @(posedge clka);
        #3;
        rst_n = 1'b0;
        #1;
        checks++; if (req2 !== 1'b0 || pend2 !== 2'd0 || ovf2 !== 1'b0 || done2 !== 1'b0) begin errors++; $display("FAIL rstmid_async: req=%b pend=%0d ovf=%b done=%b required all 0", req2, pend2, ovf2, done2); end
        repeat (2) tick;
        rst_n = 1'b1;
        repeat (3) tick;
        checks++; if (busy2 !== 1'b0 || req2 !== 1'b0) begin errors++; $display("FAIL rstmid_idle: busy=%b req=%b required 0 0", busy2, req2); end
    endtask

    task test_spurious_ack;
        logic saw_req, saw_done, saw_busy;
        int d0;
        saw_req = 1'b0; saw_done = 1'b0; saw_busy = 1'b0;
        ack_in = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (i == 4) ack_in = 1'b0;
            tick;
            saw_req  |= req_out;
            saw_done |= done_pulse;
            saw_busy |= busy;
        end
        checks++; if (saw_req !== 1'b0) begin errors++; $display("FAIL spur_req: got %b required 0", saw_req); end
        checks++; if (saw_done !== 1'b0 || saw_busy !== 1'b0) begin errors++; $display("FAIL spur_idle: done=%b busy=%b required 0 0", saw_done, saw_busy); end
        d0 = dones;
        pulse_ina = 1'b1;
        tick;
        pulse_ina = 1'b0;
        respond(1);
        wait_idle;
        tick;
        checks++; if (dones - d0 != 1) begin errors++; $display("FAIL spur_recover: got %0d dones required 1", dones - d0); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #19;
        test_reset;
        #1;
        rst_n = 1'b1;
        test_single_pulse;
        test_burst;
        test_simultaneous;
        test_overflow;
        test_reset_mid;
        test_spurious_ack;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
